// File: rtl/ctrl_pkg.sv
// Shared state codes, opcode constants and datapath select encodings for the
// multicycle RV32I control path (also imported by ALUCONTROL).
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF     = 4'b0001,
        S_ID     = 4'b0010,
        S_JUMP   = 4'b0011,
        S_MEM_RD = 4'b0100,
        S_EX_I   = 4'b0101,
        S_MEM_WR = 4'b0110,
        S_EX_R   = 4'b0111,
        S_BR_TGT = 4'b1000,
        S_EX_BR  = 4'b1001,
        S_WB     = 4'b1010,
        S_UPPER  = 4'b1011,
        S_HALT   = 4'b1111
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MDR = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic PC_SRC_PC4 = 1'b0;
    localparam logic PC_SRC_ALU = 1'b1;

    typedef struct packed {
        logic       i_mem_req;
        logic       ir_write;
        logic       d_mem_req;
        logic       d_mem_wen;
        logic       mdr_write;
        logic       pc_write;
        logic       pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       halt;
    } ctrl_t;

    // Instruction class dispatch out of decode; unknown opcodes park the core.
    function automatic state_t id_next(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_STORE, OP_IMM: return S_EX_I;
            OP_REG:                    return S_EX_R;
            OP_BRANCH:                 return S_EX_BR;
            OP_JAL, OP_JALR:           return S_JUMP;
            OP_LUI, OP_AUIPC:          return S_UPPER;
            default:                   return S_HALT;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational state/opcode to datapath control decoder, including the
// Mealy terms that depend on memory ready and branch outcome.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] opcode,
    input  logic       br_taken,
    input  logic       i_mem_rdy,
    input  logic       d_mem_rdy,
    input  logic       rst_n,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            // Reset parks the state in IF, so the fetch request must be gated.
            S_IF: begin
                ctrl.i_mem_req = rst_n;
                ctrl.ir_write  = rst_n & i_mem_rdy;
            end
            S_ID: begin
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            S_JUMP: begin
                ctrl.alu_src_a = (opcode == OP_JAL) ? SRC_A_PC : SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.rf_we     = 1'b1;
                ctrl.wb_sel    = WB_PC4;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_src    = PC_SRC_ALU;
            end
            S_EX_I: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            S_EX_R: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_RS2;
            end
            S_EX_BR: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_RS2;
                ctrl.pc_write  = ~br_taken;
                ctrl.pc_src    = PC_SRC_PC4;
            end
            S_BR_TGT: begin
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_src    = PC_SRC_ALU;
            end
            S_UPPER: begin
                ctrl.alu_src_a = (opcode == OP_LUI) ? SRC_A_ZERO : SRC_A_PC;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                ctrl.d_mem_req = 1'b1;
                ctrl.mdr_write = d_mem_rdy;
            end
            S_MEM_WR: begin
                ctrl.d_mem_req = 1'b1;
                ctrl.d_mem_wen = 1'b1;
                ctrl.pc_write  = d_mem_rdy;
                ctrl.pc_src    = PC_SRC_PC4;
            end
            S_WB: begin
                ctrl.rf_we    = 1'b1;
                ctrl.wb_sel   = (opcode == OP_LOAD) ? WB_MDR : WB_ALU;
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_SRC_PC4;
            end
            S_HALT: begin
                ctrl.halt = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: state register, next-state
// logic and retired-instruction counter; signal decode lives in ctrl_decode.
//
//   state  | meaning
//   IF     | fetch, wait for I_MEM_RDY, load IR
//   ID     | decode, ALUOut <- branch target
//   JUMP   | JAL/JALR: link to rd, PC <- target, retire
//   EX_I   | rs1 + imm (OP-IMM, load/store address)
//   EX_R   | rs1 op rs2
//   EX_BR  | branch compare, retire if not taken
//   BR_TGT | PC <- branch target, retire
//   UPPER  | LUI/AUIPC
//   MEM_RD | load, wait for D_MEM_RDY, load MDR
//   MEM_WR | store, wait for D_MEM_RDY, retire
//   WB     | register write-back, retire
//   HALT   | unsupported opcode, parked until reset
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int NUM_INST_W = 32
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [6:0]            OPCODE,
    input  logic                  BR_TAKEN,
    input  logic                  I_MEM_RDY,
    input  logic                  D_MEM_RDY,
    output logic [10:0]           ALU_CONTROL,
    output logic [3:0]            STATE,
    output logic                  I_MEM_REQ,
    output logic                  IR_WRITE,
    output logic                  D_MEM_REQ,
    output logic                  D_MEM_WEN,
    output logic                  MDR_WRITE,
    output logic                  PC_WRITE,
    output logic                  PC_SRC,
    output logic [1:0]            ALU_SRC_A,
    output logic [1:0]            ALU_SRC_B,
    output logic                  RF_WE,
    output logic [1:0]            WB_SEL,
    output logic                  HALT,
    output logic [NUM_INST_W-1:0] NUM_INST
);

    state_t                state;
    ctrl_t                 ctrl;
    logic [NUM_INST_W-1:0] num_inst;

    ctrl_decode u_decode (
        .state     (state),
        .opcode    (OPCODE),
        .br_taken  (BR_TAKEN),
        .i_mem_rdy (I_MEM_RDY),
        .d_mem_rdy (D_MEM_RDY),
        .rst_n     (RSTn),
        .ctrl      (ctrl)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= S_IF;
        end else begin
            case (state)
                S_IF:     if (I_MEM_RDY) state <= S_ID;
                S_ID:     state <= id_next(OPCODE);
                S_JUMP:   state <= S_IF;
                S_EX_I: begin
                    case (OPCODE)
                        OP_LOAD:  state <= S_MEM_RD;
                        OP_STORE: state <= S_MEM_WR;
                        default:  state <= S_WB;
                    endcase
                end
                S_EX_R:   state <= S_WB;
                S_EX_BR:  state <= BR_TAKEN ? S_BR_TGT : S_IF;
                S_BR_TGT: state <= S_IF;
                S_UPPER:  state <= S_WB;
                S_MEM_RD: if (D_MEM_RDY) state <= S_WB;
                S_MEM_WR: if (D_MEM_RDY) state <= S_IF;
                S_WB:     state <= S_IF;
                S_HALT:   state <= S_HALT;
                default:  state <= S_IF;
            endcase
        end
    end

    // PC_WRITE doubles as the retire strobe; it is never set in HALT.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            num_inst <= '0;
        end else if (ctrl.pc_write) begin
            num_inst <= num_inst + {{(NUM_INST_W-1){1'b0}}, 1'b1};
        end
    end

    assign STATE       = state;
    assign ALU_CONTROL = {OPCODE, state};
    assign I_MEM_REQ   = ctrl.i_mem_req;
    assign IR_WRITE    = ctrl.ir_write;
    assign D_MEM_REQ   = ctrl.d_mem_req;
    assign D_MEM_WEN   = ctrl.d_mem_wen;
    assign MDR_WRITE   = ctrl.mdr_write;
    assign PC_WRITE    = ctrl.pc_write;
    assign PC_SRC      = ctrl.pc_src;
    assign ALU_SRC_A   = ctrl.alu_src_a;
    assign ALU_SRC_B   = ctrl.alu_src_b;
    assign RF_WE       = ctrl.rf_we;
    assign WB_SEL      = ctrl.wb_sel;
    assign HALT        = ctrl.halt;
    assign NUM_INST    = num_inst;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: an instruction-level model expands
// each instruction into its expected state path and retire count.
module tb_multicycle_control;

    localparam int W = 4;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OPREG  = 7'b0110011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    logic         CLK = 1'b0;
    logic         RSTn = 1'b0;
    logic [6:0]   OPCODE = 7'd0;
    logic         BR_TAKEN = 1'b0;
    logic         I_MEM_RDY = 1'b0;
    logic         D_MEM_RDY = 1'b0;
    logic [10:0]  ALU_CONTROL;
    logic [3:0]   STATE;
    logic         I_MEM_REQ, IR_WRITE, D_MEM_REQ, D_MEM_WEN, MDR_WRITE;
    logic         PC_WRITE, PC_SRC, RF_WE, HALT;
    logic [1:0]   ALU_SRC_A, ALU_SRC_B, WB_SEL;
    logic [W-1:0] NUM_INST;

    multicycle_control #(.NUM_INST_W(W)) dut (
        .CLK(CLK), .RSTn(RSTn), .OPCODE(OPCODE), .BR_TAKEN(BR_TAKEN),
        .I_MEM_RDY(I_MEM_RDY), .D_MEM_RDY(D_MEM_RDY), .ALU_CONTROL(ALU_CONTROL),
        .STATE(STATE), .I_MEM_REQ(I_MEM_REQ), .IR_WRITE(IR_WRITE),
        .D_MEM_REQ(D_MEM_REQ), .D_MEM_WEN(D_MEM_WEN), .MDR_WRITE(MDR_WRITE),
        .PC_WRITE(PC_WRITE), .PC_SRC(PC_SRC), .ALU_SRC_A(ALU_SRC_A),
        .ALU_SRC_B(ALU_SRC_B), .RF_WE(RF_WE), .WB_SEL(WB_SEL), .HALT(HALT),
        .NUM_INST(NUM_INST)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       imr, irw, dmr, dwe, mdw, pcw, pcs;
        logic [1:0] a, b;
        logic       rfwe;
        logic [1:0] wb;
        logic       hlt;
    } ctl_t;

    int n_total = 0;
    int n_bad = 0;
    int model_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic ctl_t obs_ctl();
        ctl_t o;
        o = {I_MEM_REQ, IR_WRITE, D_MEM_REQ, D_MEM_WEN, MDR_WRITE, PC_WRITE, PC_SRC,
             ALU_SRC_A, ALU_SRC_B, RF_WE, WB_SEL, HALT};
        return o;
    endfunction

    // Control outputs expected in each step of an instruction.
    function automatic ctl_t exp_ctl(input logic [3:0] st, input logic [6:0] op,
                                     input logic br, input logic irdy, input logic drdy);
        ctl_t e;
        e = '0;
        case (st)
            4'h1: begin e.imr = 1'b1; e.irw = irdy; end
            4'h2: begin e.a = 2'd1; e.b = 2'd1; end
            4'h3: begin
                e.a = (op == JAL) ? 2'd1 : 2'd0; e.b = 2'd1;
                e.rfwe = 1'b1; e.wb = 2'd2; e.pcw = 1'b1; e.pcs = 1'b1;
            end
            4'h5: e.b = 2'd1;
            4'h9: e.pcw = ~br;
            4'h8: begin e.a = 2'd1; e.b = 2'd1; e.pcw = 1'b1; e.pcs = 1'b1; end
            4'hB: begin e.a = (op == LUI) ? 2'd2 : 2'd1; e.b = 2'd1; end
            4'h4: begin e.dmr = 1'b1; e.mdw = drdy; end
            4'h6: begin e.dmr = 1'b1; e.dwe = 1'b1; e.pcw = drdy; end
            4'hA: begin e.rfwe = 1'b1; e.wb = (op == LOAD) ? 2'd1 : 2'd0; e.pcw = 1'b1; end
            4'hF: e.hlt = 1'b1;
            default: e = '0;
        endcase
        return e;
    endfunction

    // Called at a falling edge: drive inputs, check mid-cycle, advance one clock.
    task automatic do_cycle(input logic [3:0] st, input logic [6:0] op,
                            input logic irdy, input logic drdy, input logic br);
        ctl_t e;
        OPCODE = op; I_MEM_RDY = irdy; D_MEM_RDY = drdy; BR_TAKEN = br;
        #1;
        e = exp_ctl(st, op, br, irdy, drdy);
        check_val("state", 32'(STATE), 32'(st));
        check_val("alu_control", 32'(ALU_CONTROL), 32'({op, st}));
        check_val("ctl", 32'(obs_ctl()), 32'(e));
        check_val("num_inst", 32'(NUM_INST), 32'(model_cnt));
        if (e.pcw) model_cnt = (model_cnt + 1) % (1 << W);
        @(negedge CLK);
    endtask

    task automatic do_reset(input logic [6:0] op);
        OPCODE = op; I_MEM_RDY = 1'b1; D_MEM_RDY = 1'b0; BR_TAKEN = 1'b1;
        #2 RSTn = 1'b0;
        #1;
        check_val("rst_state", 32'(STATE), 32'd1);
        check_val("rst_alu_control", 32'(ALU_CONTROL), 32'({op, 4'b0001}));
        check_val("rst_ctl", 32'(obs_ctl()), 32'd0);
        check_val("rst_num_inst", 32'(NUM_INST), 32'd0);
        model_cnt = 0;
        @(negedge CLK);
        @(negedge CLK);
        check_val("rst_hold_ctl", 32'(obs_ctl()), 32'd0);
        RSTn = 1'b1;
    endtask

    // Expand one instruction into its expected state path.
    task automatic run_instr(input logic [6:0] op, input logic br, input int iw, input int dw);
        for (int k = 0; k <= iw; k++) do_cycle(4'h1, op, (k == iw), rb(), rb());
        do_cycle(4'h2, op, rb(), rb(), rb());
        case (op)
            LOAD: begin
                do_cycle(4'h5, op, rb(), rb(), rb());
                for (int k = 0; k <= dw; k++) do_cycle(4'h4, op, rb(), (k == dw), rb());
                do_cycle(4'hA, op, rb(), rb(), rb());
            end
            STORE: begin
                do_cycle(4'h5, op, rb(), rb(), rb());
                for (int k = 0; k <= dw; k++) do_cycle(4'h6, op, rb(), (k == dw), rb());
            end
            OPIMM: begin
                do_cycle(4'h5, op, rb(), rb(), rb());
                do_cycle(4'hA, op, rb(), rb(), rb());
            end
            OPREG: begin
                do_cycle(4'h7, op, rb(), rb(), rb());
                do_cycle(4'hA, op, rb(), rb(), rb());
            end
            BRANCH: begin
                do_cycle(4'h9, op, rb(), rb(), br);
                if (br) do_cycle(4'h8, op, rb(), rb(), rb());
            end
            JAL, JALR: do_cycle(4'h3, op, rb(), rb(), rb());
            LUI, AUIPC: begin
                do_cycle(4'hB, op, rb(), rb(), rb());
                do_cycle(4'hA, op, rb(), rb(), rb());
            end
            default: begin
                for (int k = 0; k < 20; k++) do_cycle(4'hF, 7'($urandom), rb(), rb(), rb());
            end
        endcase
    endtask

    logic [6:0] ops [9] = '{LOAD, STORE, OPIMM, OPREG, BRANCH, JAL, JALR, LUI, AUIPC};

    initial begin
        @(negedge CLK);
        do_reset(7'($urandom));

        run_instr(OPREG, 1'b0, 0, 0);   // ADD x0 path: 1,2,7,A
        run_instr(LOAD, 1'b0, 0, 2);    // LW with two data-wait cycles
        run_instr(BRANCH, 1'b0, 0, 0);
        run_instr(BRANCH, 1'b1, 1, 0);
        run_instr(JALR, 1'b0, 0, 0);
        run_instr(JAL, 1'b0, 2, 0);
        run_instr(LUI, 1'b0, 0, 0);
        run_instr(AUIPC, 1'b0, 0, 0);

        for (int n = 0; n < 200; n++)
            run_instr(ops[$urandom_range(0, 8)], rb(), $urandom_range(0, 2), $urandom_range(0, 2));

        // Reset lands while a store waits on D_MEM_RDY.
        for (int k = 0; k < 1; k++) do_cycle(4'h1, STORE, 1'b1, rb(), rb());
        do_cycle(4'h2, STORE, rb(), rb(), rb());
        do_cycle(4'h5, STORE, rb(), rb(), rb());
        for (int k = 0; k < 3; k++) do_cycle(4'h6, STORE, rb(), 1'b0, rb());
        D_MEM_RDY = 1'b0;
        #1;
        check_val("mem_wr_wen_before_rst", 32'(D_MEM_WEN), 32'd1);
        do_reset(STORE);

        for (int n = 0; n < 20; n++)
            run_instr(ops[$urandom_range(0, 8)], rb(), $urandom_range(0, 2), $urandom_range(0, 2));

        run_instr(7'h7F, 1'b0, 1, 0);
        do_reset(7'h7F);
        run_instr(OPREG, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RV32I core. It sequences the shared datapath through fetch, decode, execute, memory and writeback steps, and drives every datapath enable and mux select. It produces the 11-bit `{opcode, state}` word consumed by `ALUCONTROL`, and counts retired instructions. It handles variable-latency instruction and data memories via req/ready handshakes.

## Interface
Parameters:
- `NUM_INST_W`, 32, retired-instruction counter width

Ports:
- `CLK`  in  1  clock, rising edge
- `RSTn`  in  1  reset, asynchronous, active-low
- `OPCODE`  in  7  IR[6:0] from instruction register
- `BR_TAKEN`  in  1  ALU result bit 0 in branch-compare state
- `I_MEM_RDY`  in  1  instruction memory data valid
- `D_MEM_RDY`  in  1  data memory access complete
- `ALU_CONTROL`  out  11  `{OPCODE, STATE}` to `ALUCONTROL`
- `STATE`  out  4  current state code
- `I_MEM_REQ`, `IR_WRITE`  out  1  fetch request; IR load
- `D_MEM_REQ`, `D_MEM_WEN`, `MDR_WRITE`  out  1  data request; store enable; MDR load
- `PC_WRITE`  out  1  PC load, also the retire strobe
- `PC_SRC`  out  1  0 = PC+4, 1 = ALU result
- `ALU_SRC_A`  out  2  0 = rs1, 1 = PC, 2 = zero
- `ALU_SRC_B`  out  2  0 = rs2, 1 = imm, 2 = const 4
- `RF_WE`  out  1  register file write
- `WB_SEL`  out  2  0 = ALUOut, 1 = MDR, 2 = PC+4
- `HALT`  out  1  sticky on unsupported opcode
- `NUM_INST`  out  `NUM_INST_W`  retired instruction count

## Operation
State register holds 4 bits. All outputs decode from the state, except the marked Mealy terms.
- IF (0001): `I_MEM_REQ`=1. `IR_WRITE`=`I_MEM_RDY` (Mealy). Hold until `I_MEM_RDY`, then go to ID.
- ID (0010): A=PC, B=imm; ALUOut ← branch target. Next state by opcode:
  - 0000011, 0100011, 0010011 → EX_I
  - 0110011 → EX_R
  - 1100011 → EX_BR
  - 1101111, 1100111 → JUMP
  - 0110111, 0010111 → UPPER
  - anything else → HALT
- JUMP (0011): A = PC for JAL, rs1 for JALR; B=imm. Assert `RF_WE`, `WB_SEL`=2, `PC_WRITE`, `PC_SRC`=1. Retire, go to IF.
- EX_I (0101): A=rs1, B=imm. Next: load → MEM_RD, store → MEM_WR, OP-IMM → WB.
- EX_R (0111): A=rs1, B=rs2. Go to WB.
- EX_BR (1001): A=rs1, B=rs2.
  - `BR_TAKEN`=0: `PC_WRITE`, `PC_SRC`=0 (Mealy), retire, go to IF.
  - `BR_TAKEN`=1: go to BR_TGT.
- BR_TGT (1000): A=PC, B=imm. Assert `PC_WRITE`, `PC_SRC`=1. Retire, go to IF.
- UPPER (1011): A = zero for LUI, PC for AUIPC; B=imm. Go to WB.
- MEM_RD (0100): `D_MEM_REQ`=1; `MDR_WRITE`=`D_MEM_RDY`. Hold until ready, then go to WB.
- MEM_WR (0110): `D_MEM_REQ`=1, `D_MEM_WEN`=1. On `D_MEM_RDY`: `PC_WRITE`, `PC_SRC`=0 (Mealy), retire, go to IF.
- WB (1010): `RF_WE`=1. `WB_SEL`=1 if `OPCODE` is load, else 0. `PC_WRITE`, `PC_SRC`=0. Retire, go to IF.
- HALT (1111): all enables 0, `HALT`=1. Stays in HALT until reset.

Retire rule:
- `NUM_INST` increments on every cycle with `PC_WRITE`=1.
- Wraps modulo 2^`NUM_INST_W`.
- `NUM_INST` is not touched in HALT.

## Timing
- Reset: while `RSTn`=0, state=IF, `NUM_INST`=0, `HALT`=0.
- Output values during reset:
  - All enables and requests are 0; `I_MEM_REQ` is gated by `RSTn`.
  - Selects are 0.
  - `ALU_CONTROL`=`{OPCODE,4'b0001}`.
- First `I_MEM_REQ` is asserted in the first cycle after `RSTn` rises.
- Reset asserted mid-instruction: state returns to IF asynchronously and enables drop immediately; a partially executed instruction is not retired.
- Cycles per instruction with ready held high:
  - R-type, OP-IMM, LUI/AUIPC, store: 4
  - load: 5
  - branch not-taken: 3; branch taken: 4
  - JAL/JALR: 3
- Each memory wait cycle adds 1. Request stays asserted and other outputs stay stable while waiting.
- `I_MEM_RDY` and `D_MEM_RDY` are ignored outside their own states.
- `ALU_CONTROL[3:0]` always equals `STATE`; `[10:4]` always equals `OPCODE`.

## Structure
- Shared package `ctrl_pkg` holds:
  - state codes (IF…HALT)
  - opcode constants
  - encodings for `ALU_SRC_A`, `ALU_SRC_B`, `WB_SEL` and `PC_SRC`
- `ALUCONTROL` imports the same state codes.
- Natural sub-module: `ctrl_decode`, a combinational state/opcode → control-signal decoder.
- The state register, next-state logic and `NUM_INST` counter stay in the top module.

## Test plan
- ADD (0x00208033), zero-wait memory → states 1, 2, 7, A, 1. `RF_WE` in cycle 4, `NUM_INST` 0→1.
- LW with `D_MEM_RDY` low for 2 cycles → MEM_RD held 3 cycles. `MDR_WRITE` pulses once; then WB with `WB_SEL`=1; 7 cycles total.
- BEQ: `BR_TAKEN`=0 → retire in EX_BR after 3 cycles, `PC_SRC`=0. `BR_TAKEN`=1 → BR_TGT, `PC_SRC`=1, 4 cycles.
- JALR → JUMP with `ALU_SRC_A`=0, `WB_SEL`=2, `RF_WE`=`PC_WRITE`=1 in the same cycle.
- Opcode 0x7F in ID → HALT=1 and stays with no enables for 20 cycles. `RSTn` pulse → state=IF, `HALT`=0, `NUM_INST`=0.
- `RSTn` dropped during MEM_WR with `D_MEM_RDY`=0 → `D_MEM_WEN` drops asynchronously and `NUM_INST` is not incremented.
